// File: rtl/acc60_stream_accumulator_pkg.sv
// Shared widths and state encodings for the 60-bit stream accumulator slice.
package acc60_stream_accumulator_pkg;

  localparam int ACC_W = 60;
  localparam int ADD_W = 49;
  localparam int SUM_W = 61;
  localparam int CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/customAdder60_11.sv
// Combinational 60+49-bit unsigned adder stage; B is zero-extended and the carry lands in Sum[60].
module customAdder60_11 (
  input  logic [59:0] A,
  input  logic [48:0] B,
  output logic [60:0] Sum
);

  assign Sum = {1'b0, A} + {12'b0, B};

endmodule

// File: rtl/acc60_stream_accumulator.sv
// Handshaked multi-term reduction unit wrapped around customAdder60_11.
module acc60_stream_accumulator
  import acc60_stream_accumulator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] init_acc,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum;

  customAdder60_11 u_adder (
    .A   (acc_q),
    .B   (in_data),
    .Sum (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init_acc;
          ovf_d   = 1'b0;
          rem_d   = num_terms;
          state_d = (num_terms == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks an accepted beat
        if (in_valid) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[SUM_W-1];
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc60_stream_accumulator.sv
// Directed scoreboard bench for acc60_stream_accumulator.
module tb_acc60_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [59:0] init_acc;
  logic [15:0] num_terms;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_acc;
  logic        out_ovf;
  logic        busy;

  typedef struct {
    logic [59:0] acc;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  acc60_stream_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_acc  (init_acc),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Monitor: every completed output handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got acc %0h ovf %0b required no output", out_acc, out_ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_acc", {4'h0, out_acc}, {4'h0, e.acc});
        chk("sb_ovf", {63'h0, out_ovf}, {63'h0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(logic [59:0] acc, logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic start_run(logic [59:0] init, logic [15:0] n);
    start     = 1'b1;
    init_acc  = init;
    num_terms = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(logic [48:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_in_ready"},  {63'h0, in_ready},  64'h0);
    chk({tag, "_out_valid"}, {63'h0, out_valid}, 64'h0);
    chk({tag, "_out_acc"},   {4'h0, out_acc},    64'h0);
    chk({tag, "_out_ovf"},   {63'h0, out_ovf},   64'h0);
    chk({tag, "_busy"},      {63'h0, busy},      64'h0);
  endtask

  logic        pat4 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    init_acc  = '0;
    num_terms = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: 0 + 1 + 2 + 3
    push_exp(60'd6, 1'b0);
    start_run(60'd0, 16'd3);
    beat(49'd1);
    beat(49'd2);
    beat(49'd3);
    @(negedge clk);
    chk("t1_latency", {63'h0, out_valid}, 64'h1);
    tick();

    // 2: all-ones + 1 wraps to zero with carry
    push_exp(60'd0, 1'b1);
    start_run(60'hFFF_FFFF_FFFF_FFFF, 16'd1);
    beat(49'd1);
    @(negedge clk);
    chk("t2_latency", {63'h0, out_valid}, 64'h1);
    tick();

    // 3: zero terms goes straight to DONE
    push_exp(60'h123, 1'b0);
    start_run(60'h123, 16'd0);
    @(negedge clk);
    chk("t3_out_valid", {63'h0, out_valid}, 64'h1);
    chk("t3_in_ready",  {63'h0, in_ready},  64'h0);
    tick();
    @(negedge clk);
    chk("t3_idle_in_ready", {63'h0, in_ready}, 64'h0);
    chk("t3_idle_busy",     {63'h0, busy},     64'h0);
    tick();

    // 4: four max addends with stall cycles carrying junk data
    push_exp(60'h7_FFFF_FFFF_FFFC, 1'b0);
    start_run(60'd0, 16'd4);
    for (int i = 0; i < 7; i++) begin
      in_valid = pat4[i];
      in_data  = pat4[i] ? 49'h1_FFFF_FFFF_FFFF : 49'h1555;
      @(negedge clk);
      chk("t4_in_ready", {63'h0, in_ready}, 64'h1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_latency", {63'h0, out_valid}, 64'h1);
    tick();

    // 5: hold result with out_ready low while start pulses
    push_exp(60'd35, 1'b0);
    out_ready = 1'b0;
    start_run(60'd5, 16'd2);
    beat(49'd10);
    beat(49'd20);
    for (int i = 0; i < 5; i++) begin
      start     = i[0];
      init_acc  = 60'd999;
      num_terms = 16'd1;
      @(negedge clk);
      chk("t5_hold_valid", {63'h0, out_valid}, 64'h1);
      chk("t5_hold_acc",   {4'h0, out_acc},    64'd35);
      tick();
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    @(negedge clk);
    chk("t5_idle_valid", {63'h0, out_valid}, 64'h0);
    chk("t5_idle_busy",  {63'h0, busy},      64'h0);
    tick();

    // 6: reset mid-run, then a fresh single-term run
    start_run(60'd0, 16'd5);
    beat(49'd100);
    beat(49'd200);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_abort");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(60'd7, 1'b0);
    start_run(60'd0, 16'd1);
    beat(49'd7);
    @(negedge clk);
    chk("t6_latency", {63'h0, out_valid}, 64'h1);
    tick();

    repeat (3) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
